// File: rtl/sipo_block_packer_if.sv
// Handshake bundle for the SIPO block packer: word stream in, packed block out.
// slave = packer side, master = producer/consumer side.
interface sipo_block_packer_if #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 17,
   parameter int CNT_W = $clog2(DEPTH + 1)
);
   logic                   clear;
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       in_data;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [DEPTH*WIDTH-1:0] out_data;
   logic [CNT_W-1:0]       out_count;
   logic                   out_last;

   modport master (
      output clear, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_last
   );

   modport slave (
      input  clear, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, out_last
   );
endinterface

// File: rtl/sipo_block_packer.sv
// Serial-in parallel-out packer: gathers up to DEPTH words into one block, first word in the LSBs.
// Build option SIPO_ZERO_FILL_EN: clear all slots on clear and on each output handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_FILL | accepting words into the next free slot; in_ready=1
// S_HOLD | block complete and presented; in_ready=0, waits for out_ready
module sipo_block_packer #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 17,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input logic                clk,
   input logic                rst,
   sipo_block_packer_if.slave bus_if
);

   typedef enum logic [0:0] {
      S_FILL = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [CNT_W-1:0]       count_inc;
   logic [DEPTH*WIDTH-1:0] data_q, data_d;
   logic                   last_q, last_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FILL;
         count_q <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      data_d    = data_q;
      last_d    = last_q;
      count_inc = count_q + CNT_W'(1);

      if (bus_if.clear) begin
         state_d = S_FILL;
         count_d = '0;
         last_d  = 1'b0;
`ifdef SIPO_ZERO_FILL_EN
         data_d  = '0;
`endif
      end else begin
         unique case (state_q)
            S_FILL: begin
               if (bus_if.in_valid) begin
                  for (int k = 0; k < DEPTH; k++) begin
                     if (count_q == CNT_W'(k)) begin
                        data_d[k*WIDTH +: WIDTH] = bus_if.in_data;
                     end
                  end
                  count_d = count_inc;
                  // HOLD is forced at DEPTH, so the counter can never wrap
                  if ((count_inc == CNT_W'(DEPTH)) || bus_if.in_last) begin
                     state_d = S_HOLD;
                     last_d  = bus_if.in_last;
                  end
               end
            end
            S_HOLD: begin
               if (bus_if.out_ready) begin
                  state_d = S_FILL;
                  count_d = '0;
                  last_d  = 1'b0;
`ifdef SIPO_ZERO_FILL_EN
                  data_d  = '0;
`endif
               end
            end
            default: state_d = S_FILL;
         endcase
      end
   end

   // count_q holds the block's word count for the whole of HOLD
   assign bus_if.in_ready  = (state_q == S_FILL);
   assign bus_if.out_valid = (state_q == S_HOLD);
   assign bus_if.out_count = (state_q == S_HOLD) ? count_q : '0;
   assign bus_if.out_data  = data_q;
   assign bus_if.out_last  = last_q;

endmodule

// File: tb/tb_sipo_block_packer.sv
// Self-checking bench for sipo_block_packer: an 8x4 instance for most scenarios, a default 64x17 instance for the wide cases.
module tb_sipo_block_packer;
   localparam int AW  = 8;
   localparam int AD  = 4;
   localparam int ACW = $clog2(AD + 1);
   localparam int BW  = 64;
   localparam int BD  = 17;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sipo_block_packer_if #(.WIDTH(AW), .DEPTH(AD)) ia ();
   sipo_block_packer_if #(.WIDTH(BW), .DEPTH(BD)) ib ();

   sipo_block_packer #(.WIDTH(AW), .DEPTH(AD)) dut_a (.clk(clk), .rst(rst), .bus_if(ia));
   sipo_block_packer dut_b (.clk(clk), .rst(rst), .bus_if(ib));

   typedef struct {
      logic [AD*AW-1:0] data;
      logic [AD*AW-1:0] mask;
      logic [ACW-1:0]   count;
      logic             last;
   } exp_t;

   exp_t             sb[$];
   logic [AD*AW-1:0] m_data;
   int               m_count;
   int               checks = 0;
   int               errors = 0;

   // reference model of the 8x4 packer, updated for each word the bench knows was accepted
   task automatic model_accept(input logic [AW-1:0] d, input logic l);
      exp_t e;
      m_data[m_count*AW +: AW] = d;
      m_count++;
      if (m_count == AD || l) begin
         e.data  = m_data;
         e.mask  = '0;
         for (int k = 0; k < AD; k++) if (k < m_count) e.mask[k*AW +: AW] = '1;
         e.count = ACW'(m_count);
         e.last  = l;
         sb.push_back(e);
         m_data  = '0;
         m_count = 0;
      end
   endtask

   task automatic model_clear();
      m_data  = '0;
      m_count = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ia.clear = 0; ia.in_valid = 0; ia.in_data = '0; ia.in_last = 0; ia.out_ready = 0;
      ib.clear = 0; ib.in_valid = 0; ib.in_data = '0; ib.in_last = 0; ib.out_ready = 0;
      model_clear();
      #12;
      checks++;
      if (ia.in_ready !== 1'b1 || ia.out_valid !== 1'b0 || ia.out_count !== '0 ||
          ia.out_last !== 1'b0 || ia.out_data !== '0) begin
         errors++;
         $display("FAIL reset_a got rdy=%b vld=%b cnt=%0d last=%b data=%h want 1 0 0 0 0",
                  ia.in_ready, ia.out_valid, ia.out_count, ia.out_last, ia.out_data);
      end
      checks++;
      if (ib.in_ready !== 1'b1 || ib.out_valid !== 1'b0 || ib.out_count !== '0 ||
          ib.out_last !== 1'b0 || ib.out_data !== '0) begin
         errors++;
         $display("FAIL reset_b got rdy=%b vld=%b cnt=%0d last=%b want 1 0 0 0 data zero",
                  ib.in_ready, ib.out_valid, ib.out_count, ib.out_last);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_full_block();
      logic [AW-1:0] w [4];
      exp_t e;
      w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (ia.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_early_valid word %0d got out_valid=%b want 0", i, ia.out_valid);
         end
         ia.in_valid = 1'b1; ia.in_data = w[i]; ia.in_last = 1'b0;
         if (ia.in_ready) model_accept(w[i], 1'b0);
      end
      @(negedge clk);
      ia.in_valid = 1'b0;
      checks++;
      if (ia.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL full_latency got out_valid=%b want 1", ia.out_valid);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (ia.in_ready !== 1'b0 || ia.out_valid !== 1'b1 || ia.out_data !== 32'h44332211) begin
            errors++;
            $display("FAIL full_stall got rdy=%b vld=%b data=%h want 0 1 44332211",
                     ia.in_ready, ia.out_valid, ia.out_data);
         end
      end
      @(negedge clk);
      ia.out_ready = 1'b1;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL full_sb got empty scoreboard want one block");
      end else begin
         e = sb.pop_front();
         if (ia.out_valid !== 1'b1 || ((ia.out_data ^ e.data) & e.mask) !== '0 ||
             ia.out_count !== e.count || ia.out_last !== e.last) begin
            errors++;
            $display("FAIL full_block got vld=%b data=%h cnt=%0d last=%b want 1 %h %0d %b",
                     ia.out_valid, ia.out_data, ia.out_count, ia.out_last, e.data, e.count, e.last);
         end
      end
      @(negedge clk);
      ia.out_ready = 1'b0;
      checks++;
      if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1 || ia.out_count !== '0) begin
         errors++;
         $display("FAIL full_release got vld=%b rdy=%b cnt=%0d want 0 1 0",
                  ia.out_valid, ia.in_ready, ia.out_count);
      end
   endtask

   task automatic test_short_block();
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ia.in_valid = 1'b1; ia.in_data = 8'hFF; ia.in_last = 1'b0;
         if (ia.in_ready) model_accept(8'hFF, 1'b0);
      end
      @(negedge clk);
      ia.in_valid = 1'b0; ia.out_ready = 1'b1;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL short_pre_sb got empty scoreboard want one block");
      end else begin
         e = sb.pop_front();
         if (ia.out_valid !== 1'b1 || ((ia.out_data ^ e.data) & e.mask) !== '0 ||
             ia.out_count !== e.count || ia.out_last !== e.last) begin
            errors++;
            $display("FAIL short_pre_block got vld=%b data=%h cnt=%0d last=%b want 1 %h %0d %b",
                     ia.out_valid, ia.out_data, ia.out_count, ia.out_last, e.data, e.count, e.last);
         end
      end
      @(negedge clk);
      ia.out_ready = 1'b0;
      ia.in_valid = 1'b1; ia.in_data = 8'hA1; ia.in_last = 1'b0;
      if (ia.in_ready) model_accept(8'hA1, 1'b0);
      @(negedge clk);
      ia.in_data = 8'hB2; ia.in_last = 1'b1;
      if (ia.in_ready) model_accept(8'hB2, 1'b1);
      @(negedge clk);
      ia.in_valid = 1'b0; ia.in_last = 1'b0;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL short_sb got empty scoreboard want one block");
      end else begin
         e = sb.pop_front();
         if (ia.out_valid !== 1'b1 || ((ia.out_data ^ e.data) & e.mask) !== '0 ||
             ia.out_count !== e.count || ia.out_last !== e.last) begin
            errors++;
            $display("FAIL short_block got vld=%b data=%h cnt=%0d last=%b want 1 %h %0d %b",
                     ia.out_valid, ia.out_data, ia.out_count, ia.out_last, e.data, e.count, e.last);
         end
      end
      checks++;
`ifdef SIPO_ZERO_FILL_EN
      if (ia.out_data[31:16] !== 16'h0000) begin
         errors++;
         $display("FAIL short_upper got %h want 0000", ia.out_data[31:16]);
      end
`else
      if (ia.out_data[31:16] !== 16'hFFFF) begin
         errors++;
         $display("FAIL short_upper got %h want ffff", ia.out_data[31:16]);
      end
`endif
      ia.out_ready = 1'b1;
      @(negedge clk);
      ia.out_ready = 1'b0;
      checks++;
      if (ia.out_valid !== 1'b0 || ia.out_last !== 1'b0) begin
         errors++;
         $display("FAIL short_release got vld=%b last=%b want 0 0", ia.out_valid, ia.out_last);
      end
   endtask

   task automatic test_back_to_back();
      exp_t          e;
      int            idx = 0;
      int            blocks = 0;
      int            last_hs = -1;
      bit            pending = 1'b0;
      logic [AW-1:0] pend_d = '0;
      ia.out_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && blocks < 3; cyc++) begin
         @(negedge clk);
         if (pending) begin
            model_accept(pend_d, 1'b0);
            idx++;
            pending = 1'b0;
         end
         if (ia.out_valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL b2b_sb cycle %0d got unexpected block want none", cyc);
            end else begin
               e = sb.pop_front();
               if (((ia.out_data ^ e.data) & e.mask) !== '0 || ia.out_count !== e.count ||
                   ia.out_last !== e.last || ia.in_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL b2b_block got data=%h cnt=%0d last=%b rdy=%b want %h %0d %b 0",
                           ia.out_data, ia.out_count, ia.out_last, ia.in_ready, e.data, e.count, e.last);
               end
            end
            if (last_hs >= 0) begin
               checks++;
               if (cyc - last_hs != 5) begin
                  errors++;
                  $display("FAIL b2b_gap got %0d cycles want 5", cyc - last_hs);
               end
            end
            last_hs = cyc;
            blocks++;
         end
         if (idx < 12) begin
            ia.in_valid = 1'b1;
            ia.in_data  = 8'h50 + 8'(idx);
            ia.in_last  = 1'b0;
            pending     = ia.in_ready;
            pend_d      = ia.in_data;
         end else begin
            ia.in_valid = 1'b0;
         end
      end
      @(negedge clk);
      ia.out_ready = 1'b0;
      ia.in_valid  = 1'b0;
      checks++;
      if (blocks != 3 || idx != 12 || sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_totals got blocks=%0d words=%0d left=%0d want 3 12 0", blocks, idx, sb.size());
      end
   endtask

   task automatic test_clear();
      exp_t e;
      @(negedge clk);
      ia.in_valid = 1'b1; ia.in_data = 8'hE1; ia.in_last = 1'b0;
      if (ia.in_ready) model_accept(8'hE1, 1'b0);
      @(negedge clk);
      ia.in_data = 8'hE2;
      if (ia.in_ready) model_accept(8'hE2, 1'b0);
      @(negedge clk);
      ia.clear = 1'b1; ia.in_data = 8'hE3;
      model_clear();
      checks++;
      if (ia.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL clear_ready got in_ready=%b want 1", ia.in_ready);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ia.clear = 1'b0;
         ia.in_data = 8'(i + 1);
         if (ia.in_ready) model_accept(8'(i + 1), 1'b0);
      end
      @(negedge clk);
      ia.in_valid = 1'b0; ia.out_ready = 1'b1;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL clear_sb got empty scoreboard want one block");
      end else begin
         e = sb.pop_front();
         if (ia.out_valid !== 1'b1 || ia.out_data !== 32'h04030201 ||
             ((ia.out_data ^ e.data) & e.mask) !== '0 || ia.out_count !== e.count || ia.out_last !== e.last) begin
            errors++;
            $display("FAIL clear_block got vld=%b data=%h cnt=%0d last=%b want 1 04030201 %0d %b",
                     ia.out_valid, ia.out_data, ia.out_count, ia.out_last, e.count, e.last);
         end
      end
      @(negedge clk);
      ia.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ia.in_valid = 1'b1; ia.in_data = 8'hC0 + 8'(i); ia.in_last = 1'b0;
      end
      @(negedge clk);
      ia.in_valid = 1'b0; ia.clear = 1'b1;
      @(negedge clk);
      ia.clear = 1'b0;
      checks++;
      if (ia.out_valid !== 1'b0 || ia.out_count !== '0 || ia.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL clear_hold_drop got vld=%b cnt=%0d rdy=%b want 0 0 1",
                  ia.out_valid, ia.out_count, ia.in_ready);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      ia.in_valid = 1'b1; ia.in_data = 8'h5A; ia.in_last = 1'b0;
      @(negedge clk);
      ia.in_data = 8'h6B; ia.in_last = 1'b1;
      @(negedge clk);
      ia.in_valid = 1'b0; ia.in_last = 1'b0;
      checks++;
      if (ia.out_valid !== 1'b1 || ia.out_last !== 1'b1 || ia.out_count !== ACW'(2)) begin
         errors++;
         $display("FAIL arst_pre got vld=%b last=%b cnt=%0d want 1 1 2", ia.out_valid, ia.out_last, ia.out_count);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (ia.out_valid !== 1'b0 || ia.out_count !== '0 || ia.out_last !== 1'b0 || ia.out_data !== '0) begin
         errors++;
         $display("FAIL arst_async got vld=%b cnt=%0d last=%b data=%h want 0 0 0 0",
                  ia.out_valid, ia.out_count, ia.out_last, ia.out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      @(negedge clk);
      checks++;
      if (ia.in_ready !== 1'b1 || ia.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL arst_release got rdy=%b vld=%b want 1 0", ia.in_ready, ia.out_valid);
      end
   endtask

   task automatic test_default_geometry();
      logic [BW-1:0] w0;
      w0 = 64'hDEADBEEF_01234567;
      @(negedge clk);
      ib.in_valid = 1'b1; ib.in_data = w0; ib.in_last = 1'b1;
      @(negedge clk);
      ib.in_valid = 1'b0; ib.in_last = 1'b0;
      checks++;
      if (ib.out_valid !== 1'b1 || ib.out_count !== 5'd1 || ib.out_last !== 1'b1 || ib.out_data[63:0] !== w0) begin
         errors++;
         $display("FAIL dflt_first_last got vld=%b cnt=%0d last=%b slot0=%h want 1 1 1 %h",
                  ib.out_valid, ib.out_count, ib.out_last, ib.out_data[63:0], w0);
      end
      ib.out_ready = 1'b1;
      @(negedge clk);
      ib.out_ready = 1'b0;
      for (int i = 0; i < BD; i++) begin
         @(negedge clk);
         ib.in_valid = 1'b1;
         ib.in_data  = {32'hC0DE0000, 32'(i)};
         ib.in_last  = (i == BD - 1);
      end
      @(negedge clk);
      ib.in_valid = 1'b0; ib.in_last = 1'b0;
      checks++;
      if (ib.out_valid !== 1'b1 || ib.out_count !== 5'd17 || ib.out_last !== 1'b1 ||
          ib.out_data[16*BW +: BW] !== 64'hC0DE0000_00000010 || ib.out_data[63:0] !== 64'hC0DE0000_00000000) begin
         errors++;
         $display("FAIL dflt_full_last got vld=%b cnt=%0d last=%b slot16=%h slot0=%h want 1 17 1 c0de000000000010 c0de000000000000",
                  ib.out_valid, ib.out_count, ib.out_last, ib.out_data[16*BW +: BW], ib.out_data[63:0]);
      end
      ib.out_ready = 1'b1;
      @(negedge clk);
      ib.out_ready = 1'b0;
      checks++;
      if (ib.out_valid !== 1'b0 || ib.out_count !== '0) begin
         errors++;
         $display("FAIL dflt_release got vld=%b cnt=%0d want 0 0", ib.out_valid, ib.out_count);
      end
   endtask

   initial begin
      test_reset();
      test_full_block();
      test_short_block();
      test_back_to_back();
      test_clear();
      test_async_reset();
      test_default_geometry();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d blocks want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/sipo_block_packer.md
Name: sipo_block_packer

Overview:
- Serial-in parallel-out packer with valid/ready handshakes on both sides.
- Collects up to DEPTH words of WIDTH bits into one parallel block, e.g. 17 x 64-bit words forming one SHAKE rate block for absorption.
- Supports short final blocks via in_last and reports how many words each block holds.
- Sits between the streaming message interface and the permutation/absorb logic.

Parameters:
- WIDTH, 64, bits per input word; must be at least 1.
- DEPTH, 17, words per full output block; must be at least 2.
- CNT_W, $clog2(DEPTH+1), width of the word counters; derived, not to be overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; discards any partial block.
- in_valid  input  1  input word present.
- in_ready  output  1  packer can accept a word this cycle.
- in_data  input  WIDTH  input word.
- in_last  input  1  marks the final word of a message; sampled with in_data.
- out_valid  output  1  block available.
- out_ready  input  1  consumer takes the block this cycle.
- out_data  output  DEPTH*WIDTH  packed block.
- out_count  output  CNT_W  number of valid words in the block, 1..DEPTH.
- out_last  output  1  block ends the message.

Behaviour:
- Reset (rst=1, asynchronous): state=FILL, word count=0, in_ready=1, out_valid=0, out_count=0, out_last=0, out_data all zero.
- States: FILL and HOLD.
- FILL:
  - in_ready=1 and out_valid=0.
  - Accept occurs when in_valid=1; the word is written to slot k = current count, i.e. out_data[k*WIDTH +: WIDTH]. The first word of a block therefore sits in the LSBs.
  - The count then increments.
  - If the accepted word makes count reach DEPTH, or in_last=1, go to HOLD next cycle.
  - Latch out_last=in_last and out_count=count+1 at that transition.
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_data, out_count and out_last are stable until the handshake.
  - Handshake occurs when out_ready=1; return to FILL next cycle with count=0 and out_last=0.
  - out_count reads 0 while in FILL.
- Latency:
  - out_valid rises the cycle after the completing word is accepted.
  - A full block needs DEPTH accept cycles plus one HOLD cycle at minimum.
  - No input is accepted in the handshake cycle (one-cycle bubble per block).
- in_last on word 1 yields a block with out_count=1, out_last=1.
- in_last on word DEPTH yields out_count=DEPTH, out_last=1.
- in_valid while in HOLD is ignored; the producer holds its word because in_ready=0.
- out_ready while in FILL is ignored.
- clear=1 has priority over everything except rst:
  - next state=FILL, count=0, out_valid=0, out_last=0.
  - A word presented in the same cycle is not accepted, even though in_ready shows 1.
  - A block held in HOLD is dropped.
- Counter never exceeds DEPTH; no wrap-around is possible because HOLD is forced at DEPTH.
- rst asserted mid-block or mid-HOLD: immediate return to reset values; partial contents are lost.

Optional Feature:
- Macro: SIPO_ZERO_FILL_EN
- Defined:
  - All DEPTH slots are cleared to zero on rst, on clear, and in the cycle of each output handshake.
  - Slots at index >= out_count therefore always read zero in a short block, ready for padding logic downstream.
- Undefined:
  - Slots are cleared only by rst.
  - Slots at index >= out_count hold stale data from earlier blocks and are don't-care; consumers must use out_count.
  - Saves DEPTH*WIDTH reset/clear muxes.

Test Plan:
- WIDTH=8, DEPTH=4; send 0x11,0x22,0x33,0x44 with out_ready=0 -> out_valid=1 one cycle after the 4th accept; out_data=0x44332211, out_count=4, out_last=0; in_ready=0 until out_ready=1.
- Same config; send 0xA1 then 0xB2 with in_last=1 after a prior full block 0xFFFFFFFF -> out_count=2, out_last=1. With SIPO_ZERO_FILL_EN, out_data=0x0000B2A1; without it, upper 16 bits=0xFFFF.
- Back-to-back 3 full blocks, in_valid and out_ready held high -> each block emits with exactly one bubble cycle; 12 words in, 3 blocks out, none lost or duplicated.
- Assert clear after 2 of 4 words, then send 0x01..0x04 -> single block 0x04030201, out_count=4; the clear-cycle word is not taken.
- Assert rst asynchronously mid-HOLD -> out_valid, out_count and out_last drop without waiting for a clock edge; out_data=0; in_ready=1 after release.
- in_last on the first word, DEPTH=17 and WIDTH=64 defaults -> out_count=1, out_last=1, slot 0 equals the input word.
